// File: rtl/jt89_wr_sched.sv
// Round-robin scheduler turning A/B register writes into jt89 latch/data byte strobes; tone pairs are atomic.
// Ack is combinational in the grant cycle, first strobe one clk later; requesters hold req until ack, strobes paced by GAP clken ticks.
module jt89_wr_sched #(
    parameter int GAP = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clken,
    input  logic       a_req,
    input  logic [2:0] a_reg,
    input  logic [9:0] a_val,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [2:0] b_reg,
    input  logic [9:0] b_val,
    output logic       b_ack,
    output logic       wr_n,
    output logic [7:0] din,
    output logic       busy
);
    localparam int CW = (GAP < 2) ? 1 : $clog2(GAP + 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP);

    typedef enum logic [2:0] {IDLE, LATCH, GAP1, DATA, GAP2} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          ptr_b, ptr_b_nx;
    logic [2:0]    cur_reg, cur_reg_nx;
    logic [9:0]    cur_val, cur_val_nx;
    logic [7:0]    din_q;
    logic          grant_a, grant_b;
    logic          cur_tone;
    logic [7:0]    latch_byte, data_byte;

    // Grants are gated by rst_n so no ack can escape while reset is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n && state == IDLE && cnt == '0) begin
            if (a_req && (!b_req || !ptr_b)) begin
                grant_a = 1'b1;
            end else if (b_req) begin
                grant_b = 1'b1;
            end
        end
    end

    assign cur_tone   = !cur_reg[0] && (cur_reg[2:1] != 2'b11);
    assign latch_byte = {1'b1, cur_reg, (cur_reg == 3'd6) ? {1'b0, cur_val[2:0]} : cur_val[3:0]};
    assign data_byte  = {2'b00, cur_val[9:4]};

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ptr_b_nx   = ptr_b;
        cur_reg_nx = cur_reg;
        cur_val_nx = cur_val;
        case (state)
            IDLE: begin
                if (grant_a || grant_b) begin
                    state_nx   = LATCH;
                    ptr_b_nx   = grant_a;
                    cur_reg_nx = grant_a ? a_reg : b_reg;
                    cur_val_nx = grant_a ? a_val : b_val;
                end else if (clken && cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            LATCH: begin
                cnt_nx   = GAP_LD;
                state_nx = GAP1;
            end
            GAP1: begin
                if (cnt == '0) begin
                    state_nx = cur_tone ? DATA : IDLE;
                end else if (clken) begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DATA: begin
                cnt_nx   = GAP_LD;
                state_nx = GAP2;
            end
            GAP2: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else if (clken) begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign a_ack = grant_a;
    assign b_ack = grant_b;
    assign wr_n  = !(state == LATCH || state == DATA);
    assign busy  = (state != IDLE);
    // din is only driven during a strobe and otherwise replays the last byte sent.
    assign din   = (state == LATCH) ? latch_byte :
                   (state == DATA)  ? data_byte  : din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr_b   <= 1'b0;
            cur_reg <= '0;
            cur_val <= '0;
            din_q   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ptr_b   <= ptr_b_nx;
            cur_reg <= cur_reg_nx;
            cur_val <= cur_val_nx;
            din_q   <= din;
        end
    end
endmodule

// File: doc/jt89_wr_sched.md
Name: jt89_wr_sched

Overview:
Write scheduler placed in front of the jt89 PSG write port (`wr_n`, `din`). It arbitrates between two requesters, A and B, using round-robin. Each requester presents register-level writes: a 3-bit register number and a 10-bit value. The block turns each write into the PSG's one- or two-byte latch/data sequence. Tone writes are atomic (never interleaved with another request), and consecutive PSG bytes are paced by a minimum gap counted in `clken` ticks.

Parameters:
- GAP, 32, minimum `clken` ticks between consecutive `wr_n` strobes. 0 means a strobe may follow on the next clk cycle.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clken  in  1  PSG clock enable, the same one fed to jt89
- a_req  in  1  requester A write request (level)
- a_reg  in  3  requester A register number: 0/2/4 tone0/1/2, 1/3/5/7 vol0/1/2/3, 6 noise ctrl
- a_val  in  10  requester A value
- a_ack  out  1  one-cycle pulse; A's request captured
- b_req  in  1  requester B request
- b_reg  in  3  requester B register number
- b_val  in  10  requester B value
- b_ack  out  1  one-cycle pulse; B's request captured
- wr_n  out  1  PSG write strobe, active low, one clk cycle wide
- din  out  8  PSG data byte
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, rst_n=0): wr_n=1, din=0, a_ack=b_ack=0, busy=0, state IDLE, gap counter=0, round-robin pointer favours A. Outputs take these values immediately, including mid-sequence; a partially sent tone pair is abandoned and no ack is issued for uncaptured requests.
- Handshake: a requester holds req, reg and val stable until it sees ack. Capture happens in the ack cycle. req may stay high the next cycle to present a new write.
- States: IDLE, LATCH, GAP1, DATA, GAP2.
- IDLE: if any req and gap counter==0, grant, capture reg/val, pulse the winner's ack, go to LATCH.
- Arbitration: if only one req, it wins. If both, the pointer side wins. The pointer flips to the other side after every grant.
- LATCH: one cycle with wr_n=0 and din = {1, reg[2:0], byte_lo}; load gap counter=GAP; go to GAP1.
  - byte_lo = val[3:0] for tone and vol registers.
  - byte_lo = {0, val[2:0]} for reg 6.
  - Unused val bits are ignored.
- GAP1: counter decrements on each clken. When it reaches 0: tone registers (0/2/4) go to DATA, all others go to IDLE.
- DATA: one cycle with wr_n=0 and din = {00, val[9:4]}; load counter=GAP; go to GAP2.
- GAP2: decrement on clken; at 0 go to IDLE.
- Pacing: the gap counter must reach 0 before IDLE can grant, so the gap also applies across requests.
- With GAP=0 the strobe-to-strobe distance is 2 clk cycles within a pair and at least 2 across requests (strobe, IDLE/GAP, strobe).
- Latency: request seen in IDLE with counter 0 → ack same cycle → first strobe next cycle.
- Atomicity: the ack for a new request never occurs between the LATCH and DATA of a tone pair.
- wr_n is high in every state except LATCH and DATA.
- din holds its last driven value between strobes.
- clken low for extended periods stalls only the GAP states. LATCH and DATA always last exactly one clk cycle.
- Counter width: enough bits to hold GAP. No wrap: decrement only when the counter is nonzero.

Test Plan:
1. GAP=32, clken every 16 clk; A writes reg0 val 0x2AB → a_ack pulse, then wr_n strobe with din=0x8B, then a second strobe exactly 32 clken ticks later with din=0x2A, busy low after the second gap.
2. A writes reg5 val 0x005 → single strobe with din=0xD5. A writes reg6 val 0x3FC → din=0xE4. Neither produces a DATA strobe.
3. A and B assert req in the same cycle (A reg1 val 0xF, B reg3 val 0x0) after reset → A acked first (din=0x9F), B acked after the gap (din=0xB0). Both held continuously with new data → grants alternate A,B,A,B.
4. A requests tone reg4 val 0x3FF; B asserts req during GAP1 → b_ack only after GAP2 expires; strobes are 0xCF, 0x3F, then B's byte.
5. GAP=0, clken=1 → tone write gives strobes 2 clk apart. Back-to-back vol writes are ≥2 clk apart and wr_n is never low for 2 consecutive cycles.
6. Assert rst_n=0 in the cycle after the tone LATCH strobe → wr_n=1, busy=0 immediately; no DATA strobe after release; a pending b_req is served fresh with A-first priority.
